instr_fetch: RTL and testbench

- Upstream neighbour of the main decoder. Holds the PC and fetches one instruction per retire over a req/ack instruction-memory handshake.
- Presents the instruction word, its opcode field and PC+4 to decode/execute.
- Computes the next PC from the branch/jump outcome the downstream stages return when the instruction retires.
- One instruction in flight, no prefetch. Minimum 2 cycles per instruction.

---
 rtl/mips_pkg.sv | 18 +
 rtl/instr_fetch_next_pc_logic.sv | 24 ++
 rtl/instr_fetch.sv | 87 ++++++++
 tb/tb_instr_fetch.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package mips_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPW   = 6;
    localparam int unsigned IDXW  = 26;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_e;

    localparam logic [OPW-1:0]  OPC_J            = 6'b000010;
    localparam logic [OPW-1:0]  OPC_BEQ          = 6'b000100;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_next_pc_logic.sv
// Next-PC selection: jump > taken branch > sequential.
module next_pc_logic
    import mips_pkg::*;
(
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [IDXW-1:0] instr_idx,
    input  logic [XLEN-1:0] sign_imm,
    input  logic            branch,
    input  logic            zero,
    input  logic            jump,
    output logic [XLEN-1:0] next_pc
);

    // Priority mux over the three target kinds; branch offset wraps at 32 bits.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr_idx, 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + (sign_imm << 2);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Single-issue instruction fetch: PC register, imem req/ack, retire handshake.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [OPW-1:0]  opcode,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            branch,
    input  logic            zero,
    input  logic            jump,
    input  logic [XLEN-1:0] sign_imm,
    output logic [XLEN-1:0] retire_count
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;

    // The fetch address is the PC register itself, so it is stable for the whole request.
    assign imem_addr = pc;

    next_pc_logic u_next_pc (
        .pc_plus4  (pc_plus4),
        .instr_idx (instr[IDXW-1:0]),
        .sign_imm  (sign_imm),
        .branch    (branch),
        .zero      (zero),
        .jump      (jump),
        .next_pc   (next_pc)
    );

    // Fetch FSM with registered outputs; ack only counts in FETCH, ready only in VALID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            pc           <= RESET_PC;
            pc_plus4     <= RESET_PC + 32'd4;
            instr        <= '0;
            opcode       <= '0;
            imem_req     <= 1'b0;
            instr_valid  <= 1'b0;
            retire_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        opcode      <= imem_rdata[31:26];
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (instr_ready) begin
                        pc           <= next_pc;
                        pc_plus4     <= next_pc + 32'd4;
                        retire_count <= retire_count + 32'd1;
                        instr_valid  <= 1'b0;
                        imem_req     <= 1'b1;
                        state        <= ST_FETCH;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch against a next-PC/retire-count reference model.
module tb_instr_fetch;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] pc_plus4;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] sign_imm = '0;
    logic [31:0] retire_count;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rel = 0;

    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_rc = 32'h0;
    logic [31:0] cur_word = 32'h0;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .opcode       (opcode),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .pc_plus4     (pc_plus4),
        .branch       (branch),
        .zero         (zero),
        .jump         (jump),
        .sign_imm     (sign_imm),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference next-PC computed from the architectural rules.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] word,
                                               input logic br, input logic z, input logic j,
                                               input logic [31:0] imm);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (j) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
        if (br && z) return seq + imm * 32'd4;
        return seq;
    endfunction

    // Serve one fetch with 'lat' wait cycles before the ack, checking the request side.
    task automatic do_fetch(input int lat, input logic [31:0] word);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (imem_req !== 1'b1) begin fails++; $display("FAIL fetch_req_timeout: imem_req=%b required 1", imem_req); end
        tests++;
        if (imem_addr !== exp_pc) begin fails++; $display("FAIL fetch_addr: got %h required %h", imem_addr, exp_pc); end
        for (int i = 0; i < lat; i++) begin
            imem_ack = 1'b0;
            instr_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            tests++;
            if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0) begin
                fails++;
                $display("FAIL fetch_wait_hold: req=%b addr=%h valid=%b required 1 %h 0", imem_req, imem_addr, instr_valid, exp_pc);
            end
        end
        instr_ready = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        cur_word = word;
        tests++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
            fails++;
            $display("FAIL fetch_to_valid: valid=%b req=%b required 1 0", instr_valid, imem_req);
        end
        tests++;
        if (instr !== word || opcode !== word[31:26]) begin
            fails++;
            $display("FAIL fetch_instr: instr=%h opcode=%b required %h %b", instr, opcode, word, word[31:26]);
        end
        tests++;
        if (pc_plus4 !== exp_pc + 32'd4) begin fails++; $display("FAIL fetch_pc_plus4: got %h required %h", pc_plus4, exp_pc + 32'd4); end
    endtask

    // Hold VALID for 'wt' cycles with noise on ignored inputs, then retire once.
    task automatic do_retire(input int wt, input logic br, input logic z, input logic j, input logic [31:0] imm);
        for (int i = 0; i < wt; i++) begin
            instr_ready = 1'b0;
            branch = 1'($urandom_range(0, 1));
            zero = 1'($urandom_range(0, 1));
            jump = 1'($urandom_range(0, 1));
            sign_imm = $urandom;
            imem_ack = 1'($urandom_range(0, 1));
            imem_rdata = ~cur_word;
            @(negedge clk);
            tests++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== cur_word || opcode !== cur_word[31:26] ||
                pc_plus4 !== exp_pc + 32'd4 || imem_addr !== exp_pc || retire_count !== exp_rc) begin
                fails++;
                $display("FAIL valid_hold: valid=%b req=%b instr=%h pc4=%h addr=%h rc=%0d required 1 0 %h %h %h %0d",
                         instr_valid, imem_req, instr, pc_plus4, imem_addr, retire_count,
                         cur_word, exp_pc + 32'd4, exp_pc, exp_rc);
            end
        end
        imem_ack = 1'b0;
        instr_ready = 1'b1;
        branch = br;
        zero = z;
        jump = j;
        sign_imm = imm;
        @(negedge clk);
        instr_ready = 1'b0;
        branch = 1'($urandom_range(0, 1));
        zero = 1'($urandom_range(0, 1));
        jump = 1'($urandom_range(0, 1));
        sign_imm = $urandom;
        exp_pc = model_next(exp_pc, cur_word, br, z, j, imm);
        exp_rc = exp_rc + 32'd1;
        tests++;
        if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL retire_to_fetch: req=%b valid=%b required 1 0", imem_req, instr_valid);
        end
        tests++;
        if (imem_addr !== exp_pc || pc_plus4 !== exp_pc + 32'd4) begin
            fails++;
            $display("FAIL retire_next_pc: addr=%h pc4=%h required %h %h", imem_addr, pc_plus4, exp_pc, exp_pc + 32'd4);
        end
        tests++;
        if (retire_count !== exp_rc) begin fails++; $display("FAIL retire_count: got %0d required %0d", retire_count, exp_rc); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || opcode !== 6'h0 ||
            pc_plus4 !== 32'h4 || imem_addr !== 32'h0 || retire_count !== 32'h0) begin
            fails++;
            $display("FAIL reset_values: req=%b valid=%b instr=%h opc=%b pc4=%h addr=%h rc=%0d required 0 0 0 0 4 0 0",
                     imem_req, instr_valid, instr, opcode, pc_plus4, imem_addr, retire_count);
        end
        rst_n = 1'b1;
        rel = cyc;
        exp_pc = 32'h0;
        exp_rc = 32'h0;
        tests++;
        if (imem_req !== 1'b0) begin fails++; $display("FAIL idle_no_req: imem_req=%b required 0", imem_req); end
    endtask

    task automatic test_sequential;
        logic [31:0] a;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            a = 32'(4 * k);
            tests++;
            if (imem_req !== 1'b1 || (cyc - rel) != 2 * k + 1 || imem_addr !== a) begin
                fails++;
                $display("FAIL seq_req_cycle: req=%b cycle=%0d addr=%h required 1 %0d %h", imem_req, cyc - rel, imem_addr, 2 * k + 1, a);
            end
            do_fetch(0, $urandom & 32'h03FF_FFFF);
            do_retire(0, 1'b0, 1'b0, 1'b0, 32'h0);
        end
        tests++;
        if (retire_count !== 32'd4) begin fails++; $display("FAIL seq_retire_count: got %0d required 4", retire_count); end
    endtask

    task automatic test_wait_ack;
        do_fetch(3, 32'h8C01_0004);
        tests++;
        if (instr !== 32'h8C01_0004 || opcode !== 6'b100011 || instr_valid !== 1'b1) begin
            fails++;
            $display("FAIL wait_ack_instr: instr=%h opc=%b valid=%b required 8c010004 100011 1", instr, opcode, instr_valid);
        end
        do_retire(1, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid_fetch;
        tests++;
        if (imem_req !== 1'b1) begin fails++; $display("FAIL midfetch_pre: imem_req=%b required 1", imem_req); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0 || pc_plus4 !== 32'h4 ||
            retire_count !== 32'h0 || instr !== 32'h0 || opcode !== 6'h0) begin
            fails++;
            $display("FAIL midfetch_async_reset: req=%b valid=%b addr=%h pc4=%h rc=%0d instr=%h required 0 0 0 4 0 0",
                     imem_req, instr_valid, imem_addr, pc_plus4, retire_count, instr);
        end
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        exp_pc = 32'h0;
        exp_rc = 32'h0;
        @(negedge clk);
        imem_ack = 1'b0;
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0) begin
            fails++;
            $display("FAIL midfetch_late_ack: req=%b addr=%h valid=%b instr=%h required 1 0 0 0", imem_req, imem_addr, instr_valid, instr);
        end
        do_fetch(0, 32'h0000_0001);
        do_retire(0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_branch_jump;
        // pc=4 here: jump to 0x10
        do_fetch(0, {OPC_J, 26'd4});
        do_retire(0, 1'b0, 1'b0, 1'b1, 32'h0);
        tests++;
        if (imem_addr !== 32'h0000_0010) begin fails++; $display("FAIL jump_to_10: got %h required 00000010", imem_addr); end
        do_fetch(1, {OPC_BEQ, 26'h3FF_FFFE});
        do_retire(0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE);
        tests++;
        if (imem_addr !== 32'h0000_000C) begin fails++; $display("FAIL branch_taken: got %h required 0000000c", imem_addr); end
        do_fetch(0, {OPC_J, 26'd4});
        do_retire(0, 1'b0, 1'b0, 1'b1, 32'h0);
        do_fetch(2, {OPC_BEQ, 26'h3FF_FFFE});
        do_retire(0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE);
        tests++;
        if (imem_addr !== 32'h0000_0014) begin fails++; $display("FAIL branch_not_taken: got %h required 00000014", imem_addr); end
        do_fetch(0, {OPC_BEQ, 26'h0});
        do_retire(0, 1'b1, 1'b1, 1'b0, 32'h0FFF_FFFA);
        tests++;
        if (imem_addr !== 32'h4000_0000) begin fails++; $display("FAIL branch_far: got %h required 40000000", imem_addr); end
        do_fetch(0, 32'h0800_0040);
        do_retire(0, 1'b0, 1'b0, 1'b1, 32'h0);
        tests++;
        if (imem_addr !== 32'h4000_0100) begin fails++; $display("FAIL jump_region: got %h required 40000100", imem_addr); end
        do_fetch(0, {OPC_J, 26'h0});
        do_retire(0, 1'b0, 1'b0, 1'b1, 32'h0);
        do_fetch(0, 32'h0800_0040);
        do_retire(0, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
        tests++;
        if (imem_addr !== 32'h4000_0100) begin fails++; $display("FAIL jump_over_branch: got %h required 40000100", imem_addr); end
    endtask

    task automatic test_hold;
        logic [31:0] rc0;
        rc0 = exp_rc;
        do_fetch(0, 32'h1234_5678);
        do_retire(5, 1'b0, 1'b0, 1'b0, 32'h0);
        tests++;
        if (retire_count !== rc0 + 32'd1) begin fails++; $display("FAIL hold_single_retire: got %0d required %0d", retire_count, rc0 + 32'd1); end
    endtask

    task automatic test_random;
        logic [31:0] word;
        logic [31:0] imm;
        int kind;
        for (int n = 0; n < 40; n++) begin
            word = $urandom;
            imm = 32'($urandom_range(0, 63)) - 32'd32;
            kind = $urandom_range(0, 3);
            do_fetch($urandom_range(0, 3), word);
            case (kind)
                0: do_retire($urandom_range(0, 2), 1'b0, 1'($urandom_range(0, 1)), 1'b0, imm);
                1: do_retire($urandom_range(0, 2), 1'b1, 1'b1, 1'b0, imm);
                2: do_retire($urandom_range(0, 2), 1'b1, 1'b0, 1'b0, imm);
                default: do_retire($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, imm);
            endcase
        end
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_wait_ack;
        test_reset_mid_fetch;
        test_branch_jump;
        test_hold;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
